range_tracker: RTL and testbench



---
 rtl/range_tracker.sv | 119 +++++++++++
 tb/tb_range_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/range_tracker.sv
// Windowed max/min/range/count tracker framed by go/finish, with a sticky protocol error state.
// Define RANGE_SIGNED_EN for two's-complement data and signed max/min comparisons.
module range_tracker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             finish,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] range,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             error
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone, StErr} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d, range_q, range_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, cnt_q, cnt_d;

    logic             gt_max, lt_min;
    logic [WIDTH-1:0] next_max, next_min;
    logic [CNT_W-1:0] cnt_inc;

`ifdef RANGE_SIGNED_EN
    assign gt_max = $signed(data_in) > $signed(run_max_q);
    assign lt_min = $signed(data_in) < $signed(run_min_q);
`else
    assign gt_max = data_in > run_max_q;
    assign lt_min = data_in < run_min_q;
`endif

    // Ties keep the current accumulator value.
    assign next_max = gt_max ? data_in : run_max_q;
    assign next_min = lt_min ? data_in : run_min_q;
    assign cnt_inc  = (run_cnt_q == CntMax) ? run_cnt_q : run_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        run_cnt_d = run_cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        range_d   = range_q;
        cnt_d     = cnt_q;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (go && !finish) begin
                    run_max_d = data_in;
                    run_min_d = data_in;
                    run_cnt_d = CNT_W'(1);
                    state_d   = StCollect;
                end else if (finish) begin
                    state_d = StErr;
                end
            end
            StCollect: begin
                if (go) begin
                    // Partial window is dropped; result registers keep the last good window.
                    state_d = StErr;
                end else begin
                    run_max_d = next_max;
                    run_min_d = next_min;
                    run_cnt_d = cnt_inc;
                    if (finish) begin
                        max_d   = next_max;
                        min_d   = next_min;
                        range_d = next_max - next_min;
                        cnt_d   = cnt_inc;
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            run_max_q <= '0;
            run_min_q <= '0;
            run_cnt_q <= '0;
            max_q     <= '0;
            min_q     <= '0;
            range_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            run_cnt_q <= run_cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            range_q   <= range_d;
            cnt_q     <= cnt_d;
        end
    end

    assign range   = range_q;
    assign max_out = max_q;
    assign min_out = min_q;
    assign count   = cnt_q;
    assign valid   = (state_q == StDone);
    assign busy    = (state_q == StCollect);
    assign error   = (state_q == StErr);

endmodule

// File: tb/tb_range_tracker.sv
// Directed bench for range_tracker: default instance plus a CNT_W=3 instance for saturation.
// Expected values for the signed build are selected with RANGE_SIGNED_EN.
module tb_range_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       go, finish;
    logic [7:0] data_in;

    logic [7:0] range, max_out, min_out, count;
    logic       valid, busy, error;
    logic [7:0] s_range, s_max, s_min;
    logic [2:0] s_count;
    logic       s_valid, s_busy, s_error;

    int total = 0;
    int bad   = 0;

`ifdef RANGE_SIGNED_EN
    localparam logic [7:0] BasicMax = 8'h40, BasicMin = 8'h80, BasicRange = 8'hC0;
    localparam logic [7:0] SgnMax = 8'h7F, SgnMin = 8'h80, SgnRange = 8'hFF;
`else
    localparam logic [7:0] BasicMax = 8'hF0, BasicMin = 8'h10, BasicRange = 8'hE0;
    localparam logic [7:0] SgnMax = 8'h80, SgnMin = 8'h00, SgnRange = 8'h80;
`endif

    range_tracker #(.WIDTH(8), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .go(go), .finish(finish), .data_in(data_in),
        .range(range), .max_out(max_out), .min_out(min_out), .count(count),
        .valid(valid), .busy(busy), .error(error)
    );

    range_tracker #(.WIDTH(8), .CNT_W(3)) dut_sat (
        .clock(clock), .reset(reset), .go(go), .finish(finish), .data_in(data_in),
        .range(s_range), .max_out(s_max), .min_out(s_min), .count(s_count),
        .valid(s_valid), .busy(s_busy), .error(s_error)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic g, input logic f, input logic [7:0] d);
        @(negedge clock);
        go = g; finish = f; data_in = d;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        go = 0; finish = 0; data_in = 0; reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        go = 0; finish = 0; data_in = 0; reset = 1;
        #2;
        total++; if (max_out !== 8'h00) begin bad++; $display("FAIL reset_max got=%h want=00", max_out); end
        total++; if (min_out !== 8'h00) begin bad++; $display("FAIL reset_min got=%h want=00", min_out); end
        total++; if (range !== 8'h00) begin bad++; $display("FAIL reset_range got=%h want=00", range); end
        total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h want=00", count); end
        total++; if ({valid, busy, error} !== 3'b000)
            begin bad++; $display("FAIL reset_flags got=%b want=000", {valid, busy, error}); end
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_basic();
        drive(1, 0, 8'h40);
        drive(0, 0, 8'h10);
        total++; if ({valid, busy, error} !== 3'b010)
            begin bad++; $display("FAIL basic_busy got=%b want=010", {valid, busy, error}); end
        drive(0, 0, 8'hF0);
        drive(0, 1, 8'h80);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_fin got=%b want=1", busy); end
        drive(0, 0, 8'h00);
        total++; if (max_out !== BasicMax) begin bad++; $display("FAIL basic_max got=%h want=%h", max_out, BasicMax); end
        total++; if (min_out !== BasicMin) begin bad++; $display("FAIL basic_min got=%h want=%h", min_out, BasicMin); end
        total++; if (range !== BasicRange) begin bad++; $display("FAIL basic_range got=%h want=%h", range, BasicRange); end
        total++; if (count !== 8'd4) begin bad++; $display("FAIL basic_count got=%0d want=4", count); end
        total++; if ({valid, busy, error} !== 3'b100)
            begin bad++; $display("FAIL basic_flags got=%b want=100", {valid, busy, error}); end
    endtask

    task automatic test_finish_idle();
        apply_reset();
        drive(0, 1, 8'h55);
        drive(0, 0, 8'h00);
        total++; if ({valid, busy, error} !== 3'b001)
            begin bad++; $display("FAIL fin_idle_flags got=%b want=001", {valid, busy, error}); end
        total++; if (max_out !== 8'h00) begin bad++; $display("FAIL fin_idle_max got=%h want=00", max_out); end
        drive(1, 0, 8'h05);
        drive(0, 0, 8'h03);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL fin_idle_clear got=%b want=0", error); end
        drive(0, 1, 8'h09);
        drive(0, 0, 8'h00);
        total++; if ({max_out, min_out, range, count} !== {8'h09, 8'h03, 8'h06, 8'd3})
            begin bad++; $display("FAIL fin_idle_result got=%h want=09030603", {max_out, min_out, range, count}); end
        total++; if ({valid, error} !== 2'b10)
            begin bad++; $display("FAIL fin_idle_valid got=%b want=10", {valid, error}); end
    endtask

    task automatic test_protocol_errors();
        drive(1, 0, 8'h20);
        drive(1, 0, 8'h50);
        drive(0, 0, 8'h00);
        total++; if ({valid, busy, error} !== 3'b001)
            begin bad++; $display("FAIL go_collect_flags got=%b want=001", {valid, busy, error}); end
        total++; if ({max_out, min_out, range, count} !== {8'h09, 8'h03, 8'h06, 8'd3})
            begin bad++; $display("FAIL go_collect_hold got=%h want=09030603", {max_out, min_out, range, count}); end
        drive(1, 0, 8'h01);
        drive(0, 1, 8'h02);
        drive(0, 0, 8'h00);
        total++; if ({max_out, min_out, range, count} !== {8'h02, 8'h01, 8'h01, 8'd2})
            begin bad++; $display("FAIL min_window got=%h want=02010102", {max_out, min_out, range, count}); end
        drive(1, 1, 8'h77);
        drive(0, 0, 8'h00);
        total++; if ({valid, busy, error} !== 3'b001)
            begin bad++; $display("FAIL go_fin_flags got=%b want=001", {valid, busy, error}); end
        total++; if ({max_out, min_out, range, count} !== {8'h02, 8'h01, 8'h01, 8'd2})
            begin bad++; $display("FAIL go_fin_hold got=%h want=02010102", {max_out, min_out, range, count}); end
    endtask

    task automatic test_saturation();
        logic [7:0] vals [10];
        vals = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h05, 8'h25, 8'h26, 8'h60, 8'h28, 8'h29};
        for (int i = 0; i < 10; i++) drive(i == 0, i == 9, vals[i]);
        drive(0, 0, 8'h00);
        total++; if (s_count !== 3'd7) begin bad++; $display("FAIL sat_count got=%0d want=7", s_count); end
        total++; if ({s_max, s_min, s_range} !== {8'h60, 8'h05, 8'h5B})
            begin bad++; $display("FAIL sat_result got=%h want=60055b", {s_max, s_min, s_range}); end
        total++; if ({s_valid, s_error} !== 2'b10)
            begin bad++; $display("FAIL sat_flags got=%b want=10", {s_valid, s_error}); end
        total++; if (count !== 8'd10) begin bad++; $display("FAIL wide_count got=%0d want=10", count); end
    endtask

    task automatic test_signed_vectors();
        drive(1, 0, 8'h80);
        drive(0, 0, 8'h7F);
        drive(0, 1, 8'h00);
        drive(0, 0, 8'h00);
        total++; if (max_out !== SgnMax) begin bad++; $display("FAIL sgn_max got=%h want=%h", max_out, SgnMax); end
        total++; if (min_out !== SgnMin) begin bad++; $display("FAIL sgn_min got=%h want=%h", min_out, SgnMin); end
        total++; if (range !== SgnRange) begin bad++; $display("FAIL sgn_range got=%h want=%h", range, SgnRange); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 8'h11);
        drive(0, 0, 8'h22);
        drive(0, 0, 8'h33);
        @(posedge clock);
        #2 reset = 1;
        #1;
        total++; if ({max_out, min_out, range, count} !== 32'h0)
            begin bad++; $display("FAIL rst_mid_results got=%h want=0", {max_out, min_out, range, count}); end
        total++; if ({valid, busy, error} !== 3'b000)
            begin bad++; $display("FAIL rst_mid_flags got=%b want=000", {valid, busy, error}); end
        @(negedge clock);
        reset = 0; go = 0; finish = 0;
        drive(1, 0, 8'h04);
        drive(0, 1, 8'h0C);
        drive(0, 0, 8'h00);
        total++; if ({max_out, min_out, range, count} !== {8'h0C, 8'h04, 8'h08, 8'd2})
            begin bad++; $display("FAIL rst_mid_after got=%h want=0c040802", {max_out, min_out, range, count}); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rst_mid_valid got=%b want=1", valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_finish_idle();
        test_protocol_errors();
        test_saturation();
        test_signed_vectors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
